dvp_axis_capture: RTL and testbench

DVP_AXIS_CAPTURE -- requirements
Module: dvp_axis_capture

---
 rtl/dvp_axis_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_dvp_axis_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_axis_capture.sv
// rtl/dvp_axis_capture.sv - DVP camera byte stream to 24-bit AXI-Stream pixel capture
// Assembles camera bytes into pixels, frames them with tuser/tlast and buffers them in a FIFO.
module dvp_axis_capture #(
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        pix_ce,
    input  logic [7:0]  din,
    input  logic        href,
    input  logic        vsync,
    input  logic        en_capture,
    input  logic        ovf_clr,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [31:0] status
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BPP = (MODE == 0) ? 3 : (MODE == 1) ? 2 : 1;
    localparam logic [1:0]  LAST_BYTE = 2'(BPP - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} state_t;

    state_t            state_q;
    logic              vsync_prev_q;
    logic              href_prev_q;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       asm_q, asm_d;
    logic              pend_valid_q, pend_valid_d;
    logic [23:0]       pend_q, pend_d;
    logic              push_q, push_d;
    logic              push_last_q, push_last_d;
    logic [23:0]       push_data_q, push_data_d;
    logic              first_q;
    logic [CNT_W-1:0]  line_cnt_q;
    logic [11:0]       line_last_q;
    logic [15:0]       frame_cnt_q;
    logic              ovf_q;
    logic              misalign_q;

    logic [25:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;

    logic              vs_rise;
    logic              href_fall;
    logic              byte_in;
    logic              px_done;
    logic [23:0]       px_word;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_try;
    logic              ovf_evt;
    logic              wr_en;
    logic              enter_active;
    logic              frame_end;
    logic              misalign_evt;
    logic [25:0]       head;

    assign vs_rise      = pix_ce & vsync & ~vsync_prev_q;
    assign href_fall    = pix_ce & ~href & href_prev_q;
    assign byte_in      = pix_ce & href & (state_q == ACTIVE);
    assign px_done      = byte_in & (byte_cnt_q == LAST_BYTE);
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == FULL_CNT);
    assign pop          = ~fifo_empty & m_axis_tready;
    // A full FIFO still accepts the push when a beat leaves in the same cycle.
    assign push_try     = push_q & (state_q == ACTIVE);
    assign ovf_evt      = push_try & fifo_full & ~pop;
    assign wr_en        = push_try & ~ovf_evt;
    assign frame_end    = vs_rise & ((state_q == ACTIVE) | (state_q == DROP));
    assign enter_active = vs_rise & ((state_q == WAIT_VS) | ((state_q != IDLE) & en_capture));
    assign misalign_evt = href_fall & (state_q == ACTIVE) & ~vs_rise & (byte_cnt_q != 2'd0);

    always_comb begin
        px_word = {asm_q, din};
        if (MODE == 1) begin
            px_word = {asm_q[7:3], asm_q[7:5],
                       asm_q[2:0], din[7:5], asm_q[2:1],
                       din[4:0], din[4:2]};
        end else if (MODE == 2) begin
            px_word = {din, din, din};
        end
    end

    // One pixel is kept pending so the last pixel of a line can be tagged with tlast.
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        push_d       = 1'b0;
        push_last_d  = 1'b0;
        push_data_d  = push_data_q;
        if (vs_rise || state_q != ACTIVE) begin
            byte_cnt_d   = 2'd0;
            pend_valid_d = 1'b0;
        end else if (px_done) begin
            byte_cnt_d   = 2'd0;
            push_d       = pend_valid_q;
            push_data_d  = pend_q;
            pend_valid_d = 1'b1;
            pend_d       = px_word;
        end else if (byte_in) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = {asm_q[7:0], din};
        end else if (href_fall) begin
            byte_cnt_d   = 2'd0;
            push_d       = pend_valid_q;
            push_last_d  = 1'b1;
            push_data_d  = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en_capture) state_q <= WAIT_VS;
                WAIT_VS: if (vs_rise) state_q <= ACTIVE;
                ACTIVE, DROP: begin
                    if (vs_rise)
                        state_q <= en_capture ? ACTIVE : IDLE;
                    else if (state_q == ACTIVE && ovf_evt)
                        state_q <= DROP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 16'd0;
            pend_valid_q <= 1'b0;
            pend_q       <= 24'd0;
            push_q       <= 1'b0;
            push_last_q  <= 1'b0;
            push_data_q  <= 24'd0;
            first_q      <= 1'b0;
            line_cnt_q   <= '0;
            line_last_q  <= 12'd0;
            frame_cnt_q  <= 16'd0;
            ovf_q        <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            if (pix_ce) begin
                vsync_prev_q <= vsync;
                href_prev_q  <= href;
            end
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            push_q       <= push_d;
            push_last_q  <= push_last_d;
            push_data_q  <= push_data_d;

            if (enter_active)
                first_q <= 1'b1;
            else if (wr_en)
                first_q <= 1'b0;

            if (vs_rise)
                line_cnt_q <= '0;
            else if (href_fall && (state_q == ACTIVE || state_q == DROP))
                line_cnt_q <= line_cnt_q + CNT_W'(1);

            if (frame_end)
                line_last_q <= 12'(line_cnt_q);
            if (vs_rise && state_q == ACTIVE)
                frame_cnt_q <= frame_cnt_q + 16'd1;

            if (ovf_evt)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;

            if (misalign_evt)
                misalign_q <= 1'b1;
            else if (ovf_clr)
                misalign_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {first_q, push_last_q, push_data_q};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? head[23:0] : 24'd0;
    assign m_axis_tlast  = m_axis_tvalid & head[24];
    assign m_axis_tuser  = m_axis_tvalid & head[25];
    assign overflow      = ovf_q;
    assign status        = {frame_cnt_q, line_last_q, fifo_empty, misalign_q, ovf_q, state_q != IDLE};

endmodule

// File: tb/tb_dvp_axis_capture.sv
// tb/tb_dvp_axis_capture.sv - directed bench for dvp_axis_capture in RGB888, RGB565 and RAW8 modes
module tb_dvp_axis_capture;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        pix_ce;
    logic [7:0]  din;
    logic        href;
    logic        vsync;
    logic        en_capture;
    logic        ovf_clr;
    logic        tready;

    logic [23:0] td0, td1, td2;
    logic        tv0, tv1, tv2;
    logic        tu0, tu1, tu2;
    logic        tl0, tl1, tl2;
    logic        ov0, ov1, ov2;
    logic [31:0] st0, st1, st2;

    int total = 0;
    int bad   = 0;

    logic [25:0] q0[$];
    logic [25:0] q1[$];
    logic [25:0] q2[$];

    always #5 aclk = ~aclk;

    dvp_axis_capture #(.MODE(0), .FIFO_DEPTH(4), .CNT_W(12)) u0 (
        .aclk(aclk), .aresetn(aresetn), .pix_ce(pix_ce), .din(din), .href(href), .vsync(vsync),
        .en_capture(en_capture), .ovf_clr(ovf_clr), .m_axis_tdata(td0), .m_axis_tvalid(tv0),
        .m_axis_tready(tready), .m_axis_tuser(tu0), .m_axis_tlast(tl0), .overflow(ov0), .status(st0));

    dvp_axis_capture #(.MODE(1), .FIFO_DEPTH(16), .CNT_W(12)) u1 (
        .aclk(aclk), .aresetn(aresetn), .pix_ce(pix_ce), .din(din), .href(href), .vsync(vsync),
        .en_capture(en_capture), .ovf_clr(ovf_clr), .m_axis_tdata(td1), .m_axis_tvalid(tv1),
        .m_axis_tready(tready), .m_axis_tuser(tu1), .m_axis_tlast(tl1), .overflow(ov1), .status(st1));

    dvp_axis_capture #(.MODE(2), .FIFO_DEPTH(16), .CNT_W(12)) u2 (
        .aclk(aclk), .aresetn(aresetn), .pix_ce(pix_ce), .din(din), .href(href), .vsync(vsync),
        .en_capture(en_capture), .ovf_clr(ovf_clr), .m_axis_tdata(td2), .m_axis_tvalid(tv2),
        .m_axis_tready(tready), .m_axis_tuser(tu2), .m_axis_tlast(tl2), .overflow(ov2), .status(st2));

    always @(negedge aclk) begin
        if (tv0 && tready) q0.push_back({tu0, tl0, td0});
        if (tv1 && tready) q1.push_back({tu1, tl1, td1});
        if (tv2 && tready) q2.push_back({tu2, tl2, td2});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bt(input logic u, input logic l, input logic [23:0] d);
        return {6'd0, u, l, d};
    endfunction

    function automatic logic [31:0] beat(input int which, input int idx);
        if (which == 0) return (idx < q0.size()) ? {6'd0, q0[idx]} : 32'hFFFF_FFFF;
        if (which == 1) return (idx < q1.size()) ? {6'd0, q1[idx]} : 32'hFFFF_FFFF;
        return (idx < q2.size()) ? {6'd0, q2[idx]} : 32'hFFFF_FFFF;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic cam(input logic [7:0] d, input logic h, input logic v);
        @(posedge aclk); #1;
        pix_ce = 1'b1; din = d; href = h; vsync = v;
        @(posedge aclk); #1;
        pix_ce = 1'b0;
    endtask

    task automatic vs_pulse;
        cam(8'h00, 1'b0, 1'b1);
        cam(8'h00, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic line(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) cam(first + 8'(i), 1'b1, 1'b0);
        cam(8'h00, 1'b0, 1'b0);
        idle(4);
    endtask

    task automatic clr_q;
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic pulse_clr;
        @(posedge aclk); #1; ovf_clr = 1'b1;
        @(posedge aclk); #1; ovf_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        aresetn = 1'b0; pix_ce = 1'b0; din = 8'h00; href = 1'b0; vsync = 1'b0;
        en_capture = 1'b0; ovf_clr = 1'b0; tready = 1'b1;
        idle(3);
        chk("rst_flags", {28'd0, tv0, tu0, tl0, ov0}, 32'h0);
        chk("rst_tdata", {8'd0, td0}, 32'h0);
        chk("rst_status", st0, 32'h0000_0008);

        aresetn = 1'b1; en_capture = 1'b1;
        idle(3);
        chk("wait_vs_status", st0, 32'h0000_0009);

        // two lines of four RGB888 pixels
        vs_pulse;
        clr_q;
        line(8'h01, 12);
        line(8'h11, 12);
        chk("f1_beats", 32'(q0.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            b = (i < 4 ? 8'h01 : 8'h11) + 8'(3 * (i % 4));
            chk($sformatf("f1_beat%0d", i), beat(0, i), bt(i == 0, i == 3 || i == 7, {b, b + 8'd1, b + 8'd2}));
        end
        vs_pulse;
        chk("f1_status", st0, 32'h0001_0029);

        // RGB565 and RAW8 expansion
        clr_q;
        cam(8'hF8, 1'b1, 1'b0); cam(8'h1F, 1'b1, 1'b0); cam(8'h5A, 1'b1, 1'b0);
        cam(8'hF8, 1'b1, 1'b0); cam(8'h1F, 1'b1, 1'b0); cam(8'h5A, 1'b1, 1'b0);
        cam(8'h00, 1'b0, 1'b0);
        idle(6);
        chk("m1_beat0", beat(1, 0), bt(1'b1, 1'b0, 24'hFF00FF));
        chk("m1_beat1", beat(1, 1), bt(1'b0, 1'b0, 24'h5A5DC6));
        chk("m1_beat2", beat(1, 2), bt(1'b0, 1'b1, 24'h18EBD6));
        chk("m2_beat0", beat(2, 0), bt(1'b1, 1'b0, 24'hF8F8F8));
        chk("m2_beat2", beat(2, 2), bt(1'b0, 1'b0, 24'h5A5A5A));
        chk("m0_beat0", beat(0, 0), bt(1'b1, 1'b0, 24'hF81F5A));
        chk("m0_beat1", beat(0, 1), bt(1'b0, 1'b1, 24'hF81F5A));
        vs_pulse;
        chk("f2_status", st0, 32'h0002_0019);

        // href falls after seven bytes
        clr_q;
        line(8'h21, 7);
        chk("mis_beats", 32'(q0.size()), 32'd2);
        chk("mis_beat0", beat(0, 0), bt(1'b1, 1'b0, 24'h212223));
        chk("mis_beat1", beat(0, 1), bt(1'b0, 1'b1, 24'h242526));
        chk("mis_flag", 32'(st0[2]), 32'h1);
        pulse_clr;
        chk("mis_cleared", 32'(st0[2]), 32'h0);
        vs_pulse;

        // overflow with a stalled sink
        tready = 1'b0;
        clr_q;
        line(8'h31, 18);
        chk("ovf_out", 32'(ov0), 32'h1);
        chk("ovf_status", 32'(st0[1]), 32'h1);
        chk("ovf_held_valid", 32'(tv0), 32'h1);
        chk("ovf_held_head", {6'd0, tu0, tl0, td0}, bt(1'b1, 1'b0, 24'h313233));
        line(8'h90, 3);
        vs_pulse;
        tready = 1'b1;
        idle(8);
        chk("ovf_drain_beats", 32'(q0.size()), 32'd4);
        chk("ovf_drain3", beat(0, 3), bt(1'b0, 1'b0, 24'h3A3B3C));
        chk("ovf_empty", {28'd0, st0[3:0]}, 32'h0000_000B);
        clr_q;
        line(8'h51, 6);
        chk("clean_beat0", beat(0, 0), bt(1'b1, 1'b0, 24'h515253));
        chk("clean_beat1", beat(0, 1), bt(1'b0, 1'b1, 24'h545556));
        pulse_clr;
        chk("ovf_cleared", {30'd0, ov0, st0[1]}, 32'h0);
        chk("frames_after_drop", {16'd0, st0[31:16]}, 32'd3);

        // en_capture dropped mid-frame
        en_capture = 1'b0;
        clr_q;
        line(8'h61, 3);
        chk("en_off_beat", beat(0, 0), bt(1'b0, 1'b1, 24'h616263));
        vs_pulse;
        chk("idle_status", st0, 32'h0004_0028);
        clr_q;
        line(8'h6A, 3);
        chk("idle_no_beats", 32'(q0.size()), 32'd0);

        // reset pulsed mid-line
        en_capture = 1'b1;
        idle(2);
        vs_pulse;
        tready = 1'b0;
        for (int i = 0; i < 6; i++) cam(8'h71 + 8'(i), 1'b1, 1'b0);
        idle(2);
        chk("pre_rst_valid", 32'(tv0), 32'h1);
        cam(8'h77, 1'b1, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tv0), 32'h0);
        chk("mid_rst_status", st0, 32'h0000_0008);
        idle(3);
        aresetn = 1'b1;
        tready = 1'b1;
        clr_q;
        cam(8'h78, 1'b1, 1'b0); cam(8'h79, 1'b1, 1'b0); cam(8'h7A, 1'b1, 1'b0);
        cam(8'h00, 1'b0, 1'b0);
        idle(4);
        chk("post_rst_none", 32'(q0.size()), 32'd0);
        chk("post_rst_status", st0, 32'h0000_0009);
        vs_pulse;
        line(8'h81, 3);
        chk("post_rst_beats", 32'(q0.size()), 32'd1);
        chk("post_rst_beat0", beat(0, 0), bt(1'b1, 1'b1, 24'h818283));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
